// File: rtl/ip_loop_seq.sv
// ip_loop_seq: BCD instruction-pointer sequencer with bracket-matching scan.
// A Request either steps the pointer by one or, on a taken bracket, scans for
// the matching bracket while counting nesting depth in BCD.
// Optional jump cache of {valid, src, dst} entries: define LOOP_JUMP_CACHE_EN.
module ip_loop_seq #(
  parameter int unsigned IP_DIGITS = 5,
  parameter int unsigned LOOP_DIGITS = 3,
  parameter int unsigned INSN_WIDTH = 4,
  parameter logic [INSN_WIDTH-1:0] OPEN_CODE = 4'h7,
  parameter logic [INSN_WIDTH-1:0] CLOSE_CODE = 4'h8,
  parameter int unsigned CACHE_DEPTH = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Request,
  output logic                    Ready,
  input  logic                    DataIsZero,
  output logic [IP_DIGITS*4-1:0]  Address,
  output logic [LOOP_DIGITS*4-1:0] LoopCount,
  output logic [INSN_WIDTH-1:0]   Insn,
  output logic                    RomReq,
  output logic [IP_DIGITS*4-1:0]  RomAddr,
  input  logic                    RomAck,
  input  logic [INSN_WIDTH-1:0]   RomData,
  input  logic                    CacheFlush,
  output logic                    Fault
);

  localparam int unsigned IPW = IP_DIGITS * 4;
  localparam int unsigned LCW = LOOP_DIGITS * 4;

  localparam logic [4:0] S_IDLE       = 5'b00001;
  localparam logic [4:0] S_FETCH      = 5'b00010;
  localparam logic [4:0] S_SCAN_FETCH = 5'b00100;
  localparam logic [4:0] S_READY      = 5'b01000;
  localparam logic [4:0] S_FAULT      = 5'b10000;

  logic [4:0]     state;
  logic [IPW-1:0] addr, addr_nxt, start_addr;
  logic [LCW-1:0] loop_cnt;
  logic [INSN_WIDTH-1:0] insn;
  logic rom_req, fault, started, launch, scan_fwd;

  // Per-digit BCD +/-1 with wrap (all-9s+1 -> 0, 0-1 -> all-9s).
  function automatic logic [IPW-1:0] ip_step(input logic [IPW-1:0] a, input logic down);
    logic [IPW-1:0] r;
    logic c;
    r = a;
    c = 1'b1;
    for (int unsigned i = 0; i < IP_DIGITS; i++) begin
      if (c) begin
        if (!down) begin
          if (a[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
          else begin r[i*4 +: 4] = a[i*4 +: 4] + 4'd1; c = 1'b0; end
        end else begin
          if (a[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
          else begin r[i*4 +: 4] = a[i*4 +: 4] - 4'd1; c = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [LCW-1:0] lc_step(input logic [LCW-1:0] a, input logic down);
    logic [LCW-1:0] r;
    logic c;
    r = a;
    c = 1'b1;
    for (int unsigned i = 0; i < LOOP_DIGITS; i++) begin
      if (c) begin
        if (!down) begin
          if (a[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
          else begin r[i*4 +: 4] = a[i*4 +: 4] + 4'd1; c = 1'b0; end
        end else begin
          if (a[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
          else begin r[i*4 +: 4] = a[i*4 +: 4] - 4'd1; c = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  logic ack, same_kind, counterpart, scan_req, scan_dir_fwd, loop_at_max;
  logic [LCW-1:0] loop_inc;

  assign ack          = rom_req & RomAck;
  assign same_kind    = scan_fwd ? (RomData == OPEN_CODE) : (RomData == CLOSE_CODE);
  assign counterpart  = scan_fwd ? (RomData == CLOSE_CODE) : (RomData == OPEN_CODE);
  assign scan_dir_fwd = (insn == OPEN_CODE);
  assign scan_req     = ((insn == OPEN_CODE) & DataIsZero) | ((insn == CLOSE_CODE) & ~DataIsZero);
  assign loop_inc     = lc_step(loop_cnt, 1'b0);
  assign loop_at_max  = (loop_inc == '0);

  assign Ready     = ~Request & ((state == S_IDLE) | (state == S_READY));
  assign Address   = addr;
  assign RomAddr   = addr;
  assign LoopCount = loop_cnt;
  assign Insn      = insn;
  assign RomReq    = rom_req;
  assign Fault     = fault;

`ifdef LOOP_JUMP_CACHE_EN
  localparam int unsigned PTRW = $clog2(CACHE_DEPTH);

  logic [CACHE_DEPTH-1:0] c_valid;
  logic [IPW-1:0] c_src [CACHE_DEPTH];
  logic [IPW-1:0] c_dst [CACHE_DEPTH];
  logic [PTRW-1:0] c_ptr;
  logic hit, scan_done;
  logic [IPW-1:0] hit_dst;

  assign scan_done = (state == S_SCAN_FETCH) & ~launch & ack & counterpart & (loop_cnt == '0);

  // Look up the current pointer as a jump source.
  always_comb begin
    hit = 1'b0;
    hit_dst = '0;
    for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
      if (c_valid[i] && (c_src[i] == addr)) begin
        hit = 1'b1;
        hit_dst = c_dst[i];
      end
    end
  end

  // Record each completed scan round-robin; flush wins over a same-edge write.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      c_valid <= '0;
      c_ptr   <= '0;
      for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
        c_src[i] <= '0;
        c_dst[i] <= '0;
      end
    end else if (CacheFlush) begin
      c_valid <= '0;
    end else if (scan_done) begin
      c_valid[c_ptr] <= 1'b1;
      c_src[c_ptr]   <= start_addr;
      c_dst[c_ptr]   <= addr;
      c_ptr          <= PTRW'(c_ptr + 1);
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{CacheFlush, CACHE_DEPTH};
`endif

  // Sequencer. Address changes only in a one-cycle launch phase that also
  // raises RomReq, so every pointer update is paired with a fresh fetch.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      addr_nxt   <= '0;
      start_addr <= '0;
      loop_cnt   <= '0;
      insn       <= '0;
      rom_req    <= 1'b0;
      fault      <= 1'b0;
      started    <= 1'b0;
      launch     <= 1'b0;
      scan_fwd   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (Request) begin
            launch <= 1'b1;
            if (!started) begin
              started  <= 1'b1;
              addr_nxt <= addr;
              state    <= S_FETCH;
            end else if (scan_req) begin
              loop_cnt   <= '0;
              start_addr <= addr;
              scan_fwd   <= scan_dir_fwd;
`ifdef LOOP_JUMP_CACHE_EN
              if (hit) begin
                addr_nxt <= hit_dst;
                state    <= S_FETCH;
              end else
`endif
              begin
                addr_nxt <= ip_step(addr, !scan_dir_fwd);
                state    <= S_SCAN_FETCH;
              end
            end else begin
              addr_nxt <= ip_step(addr, 1'b0);
              state    <= S_FETCH;
            end
          end else if (state == S_READY) begin
            state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (launch) begin
            addr    <= addr_nxt;
            rom_req <= 1'b1;
            launch  <= 1'b0;
          end else if (ack) begin
            insn    <= RomData;
            rom_req <= 1'b0;
            state   <= S_READY;
          end
        end
        S_SCAN_FETCH: begin
          if (launch) begin
            launch <= 1'b0;
            if (addr_nxt == start_addr) begin
              fault <= 1'b1;
              state <= S_FAULT;
            end else begin
              addr    <= addr_nxt;
              rom_req <= 1'b1;
            end
          end else if (ack) begin
            rom_req <= 1'b0;
            if (same_kind) begin
              if (loop_at_max) begin
                fault <= 1'b1;
                state <= S_FAULT;
              end else begin
                loop_cnt <= loop_inc;
                addr_nxt <= ip_step(addr, !scan_fwd);
                launch   <= 1'b1;
              end
            end else if (counterpart && (loop_cnt == '0)) begin
              insn  <= RomData;
              state <= S_READY;
            end else begin
              if (counterpart) loop_cnt <= lc_step(loop_cnt, 1'b1);
              addr_nxt <= ip_step(addr, !scan_fwd);
              launch   <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          rom_req <= 1'b0;
          fault   <= 1'b1;
        end
        default: begin
          rom_req <= 1'b0;
          fault   <= 1'b1;
          state   <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ip_loop_seq.sv
// Directed bench for ip_loop_seq with a behavioural ROM and an expected-result
// queue. Built with a 3-digit pointer and 1-digit depth counter so wrap and
// overflow cases stay short.
module tb_ip_loop_seq;

  localparam logic [3:0] OPC = 4'h7;
  localparam logic [3:0] CLC = 4'h8;
  localparam logic [3:0] PLS = 4'h1;
  localparam logic [3:0] MNS = 4'h2;

  logic Clk = 1'b0, Rst_n = 1'b0, Request = 1'b0, DataIsZero = 1'b0, CacheFlush = 1'b0;
  logic ack_en = 1'b1;
  logic RomAck, RomReq, Ready, Fault;
  logic [11:0] Address, RomAddr;
  logic [3:0] LoopCount, Insn, RomData;
  logic [3:0] rom [0:999];

  int vectors = 0;
  int miscompares = 0;
  int fetch_cnt = 0;
  logic [3:0] peak = '0;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  insn;
    string       tag;
  } exp_t;
  exp_t sb[$];

  function automatic int bcd2int(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  ip_loop_seq #(.IP_DIGITS(3), .LOOP_DIGITS(1), .INSN_WIDTH(4),
                .OPEN_CODE(4'h7), .CLOSE_CODE(4'h8), .CACHE_DEPTH(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Request(Request), .Ready(Ready),
    .DataIsZero(DataIsZero), .Address(Address), .LoopCount(LoopCount),
    .Insn(Insn), .RomReq(RomReq), .RomAddr(RomAddr), .RomAck(RomAck),
    .RomData(RomData), .CacheFlush(CacheFlush), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  assign RomAck  = ack_en;
  assign RomData = rom[bcd2int(RomAddr)];

  // Count acknowledged fetches and track deepest nesting seen.
  always @(posedge Clk) begin
    if (RomReq && RomAck) fetch_cnt++;
    if (LoopCount > peak) peak = LoopCount;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(input logic [3:0] code);
    for (int i = 0; i < 1000; i++) rom[i] = code;
  endtask

  task automatic do_reset();
    Request = 1'b0;
    Rst_n = 1'b0;
    #12;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  // One request; expected result queued now, compared when Ready returns.
  task automatic step(input string tag, input logic dz, input logic [11:0] ea,
                      input logic [3:0] ei, input int elat, input int efetch, input int epeak);
    int cyc;
    exp_t e;
    e.addr = ea; e.insn = ei; e.tag = tag;
    sb.push_back(e);
    fetch_cnt = 0;
    peak = '0;
    Request = 1'b1;
    DataIsZero = dz;
    @(posedge Clk); #1;
    Request = 1'b0;
    cyc = 0;
    while (Ready !== 1'b1 && cyc < 4000) begin
      @(posedge Clk); #1;
      cyc++;
    end
    check({tag, "_ready"}, 32'(Ready), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_addr"}, 32'(Address), 32'(e.addr));
      check({e.tag, "_insn"}, 32'(Insn), 32'(e.insn));
    end
    if (elat >= 0) check({tag, "_lat"}, 32'(cyc), 32'(elat));
    if (efetch >= 0) check({tag, "_fetches"}, 32'(fetch_cnt), 32'(efetch));
    if (epeak >= 0) check({tag, "_peak"}, 32'(peak), 32'(epeak));
  endtask

  // Request a scan expected to end in Fault; bounded wait.
  task automatic step_to_fault(input string tag, input int efetch);
    int cyc;
    fetch_cnt = 0;
    Request = 1'b1;
    DataIsZero = 1'b1;
    @(posedge Clk); #1;
    Request = 1'b0;
    cyc = 0;
    while (Fault !== 1'b1 && cyc < 5000) begin
      @(posedge Clk); #1;
      cyc++;
    end
    check({tag, "_fault"}, 32'(Fault), 32'd1);
    check({tag, "_ready"}, 32'(Ready), 32'd0);
    check({tag, "_romreq"}, 32'(RomReq), 32'd0);
    check({tag, "_fetches"}, 32'(fetch_cnt), 32'(efetch));
  endtask

  initial begin
    int fwd2_f, fwd2_p, back2_f, back2_p;

    // Reset state
    fill_rom(PLS);
    do_reset();
    check("rst_addr", 32'(Address), 32'd0);
    check("rst_loop", 32'(LoopCount), 32'd0);
    check("rst_insn", 32'(Insn), 32'd0);
    check("rst_romreq", 32'(RomReq), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    check("rst_ready", 32'(Ready), 32'd1);

    // Plain stepping over "+ + +"
    step("plus0", 1'b0, int2bcd(0), PLS, 2, 1, -1);
    step("plus1", 1'b0, int2bcd(1), PLS, 2, 1, -1);
    step("plus2", 1'b1, int2bcd(2), PLS, 2, 1, -1);

    // Bracket program "[ + [ - ] ] +"
    fill_rom(PLS);
    rom[0] = OPC; rom[1] = PLS; rom[2] = OPC; rom[3] = MNS;
    rom[4] = CLC; rom[5] = CLC; rom[6] = PLS;
    do_reset();
    step("br_f0", 1'b0, int2bcd(0), OPC, 2, 1, -1);
    step("fwd1", 1'b1, int2bcd(5), CLC, -1, 5, 1);
    check("fwd1_loopcnt", 32'(LoopCount), 32'd0);
    step("back1", 1'b0, int2bcd(0), OPC, -1, 5, 1);
`ifdef LOOP_JUMP_CACHE_EN
    fwd2_f = 1; fwd2_p = 0; back2_f = 1; back2_p = 0;
`else
    fwd2_f = 5; fwd2_p = 1; back2_f = 5; back2_p = 1;
`endif
    step("fwd2", 1'b1, int2bcd(5), CLC, -1, fwd2_f, fwd2_p);
    step("back2", 1'b0, int2bcd(0), OPC, -1, back2_f, back2_p);
    CacheFlush = 1'b1;
    @(posedge Clk); #1;
    CacheFlush = 1'b0;
    step("fwd3", 1'b1, int2bcd(5), CLC, -1, 5, 1);
    step("past_match", 1'b1, int2bcd(6), PLS, 2, 1, -1);

    // Wrap both ways: backward from 000 matches at 999, then steps to 000
    fill_rom(PLS);
    rom[0] = CLC;
    rom[999] = OPC;
    do_reset();
    step("wr_f0", 1'b0, int2bcd(0), CLC, 2, 1, -1);
    step("wr_back", 1'b0, int2bcd(999), OPC, -1, 1, 0);
    step("wr_inc", 1'b0, int2bcd(0), CLC, 2, 1, -1);

    // Unmatched '[' over all-'+' ROM wraps back onto its start
    fill_rom(PLS);
    rom[0] = OPC;
    do_reset();
    step("um_f0", 1'b0, int2bcd(0), OPC, 2, 1, -1);
    step_to_fault("unmatched", 999);
    Request = 1'b1;
    @(posedge Clk); #1;
    Request = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("fault_hold_ready", 32'(Ready), 32'd0);
    check("fault_hold_fault", 32'(Fault), 32'd1);
    check("fault_hold_romreq", 32'(RomReq), 32'd0);
    do_reset();
    check("fault_clear", 32'(Fault), 32'd0);
    check("fault_clear_addr", 32'(Address), 32'd0);

    // Depth counter overflow with ten nested '['
    fill_rom(PLS);
    for (int i = 0; i <= 10; i++) rom[i] = OPC;
    do_reset();
    step("ov_f0", 1'b0, int2bcd(0), OPC, 2, 1, -1);
    step_to_fault("overflow", 10);
    check("overflow_loopcnt", 32'(LoopCount), 32'd9);

    // Asynchronous reset while a fetch is outstanding
    fill_rom(PLS);
    do_reset();
    step("ar_f0", 1'b0, int2bcd(0), PLS, 2, 1, -1);
    ack_en = 1'b0;
    Request = 1'b1;
    DataIsZero = 1'b0;
    @(posedge Clk); #1;
    Request = 1'b0;
    for (int i = 0; i < 10 && RomReq !== 1'b1; i++) begin
      @(posedge Clk); #1;
    end
    check("ar_pending_req", 32'(RomReq), 32'd1);
    check("ar_pending_addr", 32'(Address), 32'(int2bcd(1)));
    #2;
    Rst_n = 1'b0;
    #1;
    check("ar_romreq", 32'(RomReq), 32'd0);
    check("ar_addr", 32'(Address), 32'd0);
    #3;
    Rst_n = 1'b1;
    ack_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
